// File: rtl/muskbus_pkg.sv
// Shared Muskbus line geometry and the writeback-queue entry layout.
package muskbus_pkg;

  localparam int unsigned LINE_BYTES = 64;
  localparam int unsigned LINE_BITS  = LINE_BYTES * 8;
  localparam int unsigned LINE_OFF_W = $clog2(LINE_BYTES);
  localparam int unsigned TAG_W      = 64 - LINE_OFF_W;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W-1:0]     tag;
    logic [0:LINE_BITS-1] data;
  } wbq_entry_t;

  function automatic logic [TAG_W-1:0] line_tag(input logic [63:0] addr);
    return addr[63:LINE_OFF_W];
  endfunction

endpackage

// File: rtl/muskbus_wbq_match.sv
// Tag search over the queue entries: per-entry match vector plus the index
// of the youngest match. With inflight_i set, the head entry is excluded.
module muskbus_wbq_match
  import muskbus_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  wbq_entry_t               entries_i [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] head_i,
  input  logic [$clog2(DEPTH):0]   count_i,
  input  logic                     inflight_i,
  input  logic [TAG_W-1:0]         tag_i,
  output logic [DEPTH-1:0]         match_o,
  output logic [$clog2(DEPTH)-1:0] idx_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] pos;

  // Compare every valid entry against the probe tag.
  always_comb begin
    match_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      match_o[i] = entries_i[i].valid && (entries_i[i].tag == tag_i) &&
                   !(inflight_i && (PTR_W'(i) == head_i));
    end
  end

  // Walk from head towards tail so the last hit seen is the youngest.
  always_comb begin
    idx_o = head_i;
    pos   = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      pos = head_i + PTR_W'(k);
      if (((PTR_W+1)'(k) < count_i) && match_o[pos]) begin
        idx_o = pos;
      end
    end
  end

endmodule

// File: rtl/muskbus_writeback_queue.sv
// Writeback queue for evicted dirty lines: accepts lines from the cache,
// coalesces re-evictions, forwards lookups, and drains the head into the
// Muskbus line writer one line at a time.
module muskbus_writeback_queue
  import muskbus_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enq_valid,
  output logic          enq_ready,
  input  logic [63:0]   enq_addr,
  input  logic [0:511]  enq_data,
  output logic          wr_reqcyc,
  output logic [63:0]   wr_addr,
  output logic [0:511]  wr_data,
  input  logic          wr_respcyc,
  input  logic [63:0]   lk_addr,
  output logic          lk_hit,
  output logic [0:511]  lk_data,
  output logic          empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} drain_state_e;

  drain_state_e     state_q, state_d;
  wbq_entry_t       entries_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic             inflight, enq_fire, enq_append, pop;
  logic [DEPTH-1:0] lk_match, co_match;
  logic [PTR_W-1:0] lk_idx, co_idx;
  logic             co_hit;
  logic             unused_offsets;

  assign unused_offsets = ^{enq_addr[LINE_OFF_W-1:0], lk_addr[LINE_OFF_W-1:0]};

  assign inflight   = (state_q != IDLE);
  assign enq_ready  = (count_q < (PTR_W+1)'(DEPTH));
  assign enq_fire   = enq_valid && enq_ready;
  assign co_hit     = |co_match;
  assign enq_append = enq_fire && !co_hit;
  assign pop        = (state_q == WAIT) && wr_respcyc;

  // Lookup sees every valid entry, including the one being written out.
  muskbus_wbq_match #(.DEPTH(DEPTH)) u_lk_match (
    .entries_i  (entries_q),
    .head_i     (head_q),
    .count_i    (count_q),
    .inflight_i (1'b0),
    .tag_i      (line_tag(lk_addr)),
    .match_o    (lk_match),
    .idx_o      (lk_idx)
  );

  // Coalescing must never touch the in-flight head.
  muskbus_wbq_match #(.DEPTH(DEPTH)) u_co_match (
    .entries_i  (entries_q),
    .head_i     (head_q),
    .count_i    (count_q),
    .inflight_i (inflight),
    .tag_i      (line_tag(enq_addr)),
    .match_o    (co_match),
    .idx_o      (co_idx)
  );

  assign lk_hit    = |lk_match;
  assign lk_data   = lk_hit ? entries_q[lk_idx].data : '0;
  assign wr_addr   = {entries_q[head_q].tag, {LINE_OFF_W{1'b0}}};
  assign wr_data   = entries_q[head_q].data;
  assign wr_reqcyc = (state_q == ISSUE);
  assign empty     = (count_q == '0) && (state_q == IDLE);

  // Drain sequencing and pointer/count bookkeeping.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    unique case (state_q)
      IDLE:    if (count_q != '0) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (wr_respcyc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (pop)        head_d = head_q + PTR_W'(1);
    if (enq_append) tail_d = tail_q + PTR_W'(1);
    unique case ({enq_append, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage: only valid bits are reset; data is don't-care when invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries_q[i].valid <= 1'b0;
      end
    end else begin
      if (pop) entries_q[head_q].valid <= 1'b0;
      if (enq_fire) begin
        if (co_hit) begin
          entries_q[co_idx].data <= enq_data;
        end else begin
          entries_q[tail_q] <= '{valid: 1'b1, tag: line_tag(enq_addr), data: enq_data};
        end
      end
    end
  end

  // A writer response is only meaningful while waiting for one.
  a_no_spurious_resp: assert property (@(posedge clk) disable iff (reset)
    wr_respcyc |-> (state_q == WAIT));

endmodule
